// File: rtl/zprize_result_serializer_pkg.sv
// ----------------------------------------------------------------------------
// zprize_param
//   Shared constants and the FSM state type for the calc-group result
//   serializer and its point FIFO.
//
//   ZPRIZE_POINT_W : width of one result point
//   ZPRIZE_BEAT_W  : width of one output beat (POINT_W is a multiple of it)
//   ZPRIZE_NPOINTS : points per frame (128 sections x {sum, tmp})
//   zs_state_t     : serializer FSM states
// ----------------------------------------------------------------------------
package zprize_param;

   localparam int unsigned ZPRIZE_POINT_W = 1536;
   localparam int unsigned ZPRIZE_BEAT_W  = 512;
   localparam int unsigned ZPRIZE_NPOINTS = 256;

   typedef enum logic {
      ZS_IDLE = 1'b0,
      ZS_RECV = 1'b1
   } zs_state_t;

endpackage

// File: rtl/zprize_pt_fifo2.sv
// ----------------------------------------------------------------------------
// zprize_pt_fifo2
//   Two-entry register FIFO holding whole result points. The head entry is
//   presented continuously so the serializer can slice it into beats.
//
//   clk       in  : clock
//   rstN      in  : asynchronous active-low reset
//   clr       in  : synchronous flush of pointers and occupancy
//   push      in  : write push_data (caller guarantees cnt < 2)
//   push_data in  : point to write
//   pop       in  : drop the head entry (caller guarantees cnt != 0)
//   cnt       out : occupancy, 0..2
//   head      out : oldest entry
// ----------------------------------------------------------------------------
module zprize_pt_fifo2
   import zprize_param::*;
#(
   parameter int unsigned POINT_W = ZPRIZE_POINT_W
) (
   input  logic               clk,
   input  logic               rstN,
   input  logic               clr,
   input  logic               push,
   input  logic [POINT_W-1:0] push_data,
   input  logic               pop,
   output logic [1:0]         cnt,
   output logic [POINT_W-1:0] head
);

   logic [1:0][POINT_W-1:0] mem_q;
   logic                    wr_ptr_q;
   logic                    rd_ptr_q;
   logic [1:0]              cnt_q;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         mem_q    <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else if (clr) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         // Simultaneous push and pop leaves occupancy unchanged.
         unique case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign cnt  = cnt_q;
   assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/zprize_result_serializer.sv
// ----------------------------------------------------------------------------
// zprize_result_serializer
//   Receives the per-window result points of one frame from the calc group,
//   buffers up to two of them and emits each as BPP beats, least-significant
//   slice first, with m_last on the final beat of the frame.
//
//   clk          in  : clock
//   rstN         in  : asynchronous active-low reset
//   start        in  : arm one frame (IDLE only)
//   idle         out : FSM in IDLE
//   done         out : one-cycle pulse the cycle after the last beat handshake
//   result_valid in  : point valid from the calc group
//   result_ready out : point accepted on result_valid && result_ready
//   result_data  in  : point payload
//   m_valid      out : beat valid
//   m_ready      in  : downstream ready
//   m_data       out : beat payload
//   m_last       out : final beat of the frame
//   pt_cnt       out : points accepted in the current frame
// ----------------------------------------------------------------------------
module zprize_result_serializer
   import zprize_param::*;
#(
   parameter int unsigned POINT_W = ZPRIZE_POINT_W,
   parameter int unsigned BEAT_W  = ZPRIZE_BEAT_W,
   parameter int unsigned NPOINTS = ZPRIZE_NPOINTS
) (
   input  logic               clk,
   input  logic               rstN,
   input  logic               start,
   output logic               idle,
   output logic               done,
   input  logic               result_valid,
   output logic               result_ready,
   input  logic [POINT_W-1:0] result_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [BEAT_W-1:0]  m_data,
   output logic               m_last,
   output logic [8:0]         pt_cnt
);

   localparam int unsigned    BPP       = POINT_W / BEAT_W;
   localparam int unsigned    BIW       = (BPP > 1) ? $clog2(BPP) : 1;
   localparam logic [BIW-1:0] LAST_BEAT = BIW'(BPP - 1);
   localparam logic [8:0]     NPTS      = 9'(NPOINTS);
   localparam logic [8:0]     LAST_PT   = 9'(NPOINTS - 1);

   zs_state_t       state_q, state_d;
   logic [8:0]      pt_cnt_q, pt_cnt_d;
   logic [8:0]      pop_cnt_q, pop_cnt_d;   // points fully serialized this frame
   logic [BIW-1:0]  beat_idx_q, beat_idx_d;
   logic            done_q, done_d;

   logic                      fifo_clr;
   logic                      push;
   logic                      pop;
   logic                      beat_hs;
   logic [1:0]                buf_cnt;
   logic [POINT_W-1:0]        head;
   logic [BPP-1:0][BEAT_W-1:0] head_beats;

   zprize_pt_fifo2 #(
      .POINT_W (POINT_W)
   ) u_fifo (
      .clk       (clk),
      .rstN      (rstN),
      .clr       (fifo_clr),
      .push      (push),
      .push_data (result_data),
      .pop       (pop),
      .cnt       (buf_cnt),
      .head      (head)
   );

   // Input readiness comes only from registered state, never from m_ready.
   assign result_ready = (state_q == ZS_RECV) && (buf_cnt < 2'd2) && (pt_cnt_q < NPTS);
   assign push         = result_valid && result_ready;

   assign head_beats = head;
   assign m_valid    = (buf_cnt != 2'd0);
   assign m_data     = m_valid ? head_beats[beat_idx_q] : '0;
   assign m_last     = m_valid && (beat_idx_q == LAST_BEAT) && (pop_cnt_q == LAST_PT);
   assign beat_hs    = m_valid && m_ready;
   assign pop        = beat_hs && (beat_idx_q == LAST_BEAT);

   assign idle   = (state_q == ZS_IDLE);
   assign done   = done_q;
   assign pt_cnt = pt_cnt_q;

   always_comb begin
      state_d    = state_q;
      pt_cnt_d   = pt_cnt_q;
      pop_cnt_d  = pop_cnt_q;
      beat_idx_d = beat_idx_q;
      done_d     = 1'b0;
      fifo_clr   = 1'b0;

      unique case (state_q)
         ZS_IDLE: begin
            if (start) begin
               state_d    = ZS_RECV;
               pt_cnt_d   = '0;
               pop_cnt_d  = '0;
               beat_idx_d = '0;
               fifo_clr   = 1'b1;
            end
         end
         ZS_RECV: begin
            if (push && (pt_cnt_q != NPTS)) begin
               pt_cnt_d = pt_cnt_q + 9'd1;
            end
            if (beat_hs) begin
               beat_idx_d = (beat_idx_q == LAST_BEAT) ? '0 : beat_idx_q + BIW'(1);
            end
            if (pop) begin
               pop_cnt_d = pop_cnt_q + 9'd1;
            end
            if (beat_hs && m_last) begin
               done_d  = 1'b1;
               state_d = ZS_IDLE;
            end
         end
         default: state_d = ZS_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q    <= ZS_IDLE;
         pt_cnt_q   <= '0;
         pop_cnt_q  <= '0;
         beat_idx_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pt_cnt_q   <= pt_cnt_d;
         pop_cnt_q  <= pop_cnt_d;
         beat_idx_q <= beat_idx_d;
         done_q     <= done_d;
      end
   end

endmodule

// File: tb/tb_zprize_result_serializer.sv
module tb_zprize_result_serializer;

   localparam int PW = 1536;
   localparam int BW = 512;
   localparam int NP = 256;

   logic          clk;
   logic          rstN;
   logic          start;
   logic          idle;
   logic          done;
   logic          rv;
   logic          rr;
   logic [PW-1:0] rdata;
   logic          mv;
   logic          mr;
   logic [BW-1:0] mdata;
   logic          mlast;
   logic [8:0]    pt_cnt;

   int errors = 0;
   int checks = 0;

   zprize_result_serializer dut (
      .clk          (clk),
      .rstN         (rstN),
      .start        (start),
      .idle         (idle),
      .done         (done),
      .result_valid (rv),
      .result_ready (rr),
      .result_data  (rdata),
      .m_valid      (mv),
      .m_ready      (mr),
      .m_data       (mdata),
      .m_last       (mlast),
      .pt_cnt       (pt_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Mode 0: every slice equals the point index. Mode 1: distinct slices per beat.
   function automatic logic [BW-1:0] mk_beat(input int mode, input int p, input int k);
      logic [31:0] w;
      if (mode == 0) return BW'(p);
      w = 32'(p * 4 + k) ^ 32'hC0DE_0000;
      return {16{w}};
   endfunction

   function automatic logic [PW-1:0] mk_point(input int mode, input int p);
      return {mk_beat(mode, p, 2), mk_beat(mode, p, 1), mk_beat(mode, p, 0)};
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chkd(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_idle"}, int'(idle), 1);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_rready"}, int'(rr), 0);
      chk({tag, "_mvalid"}, int'(mv), 0);
      chk({tag, "_mlast"}, int'(mlast), 0);
      chkd({tag, "_mdata"}, mdata, '0);
      chk({tag, "_ptcnt"}, int'(pt_cnt), 0);
   endtask

   // Streams a frame to completion against a small occupancy/scoreboard model.
   task automatic run_frame(input bit do_start, input int mode, input bit rand_ready,
                            input int sent0, input int beats0, input bit chk_lat);
      int  sent;
      int  beats;
      int  cyc;
      int  t_first;
      int  t_done;
      int  occ;
      bit  exp_mv;
      bit  exp_rr;
      bit  exp_done;
      bit  got_done;
      sent     = sent0;
      beats    = beats0;
      cyc      = 0;
      t_first  = -1;
      t_done   = -1;
      exp_done = 1'b0;
      got_done = 1'b0;
      if (do_start) begin
         start = 1'b1;
         rv    = 1'b0;
         mr    = 1'b0;
         #1;
         chk("start_idle", int'(idle), 1);
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      while (!got_done && cyc < 6000) begin
         rv    = (sent < NP);
         rdata = mk_point(mode, sent);
         mr    = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         chk("done", int'(done), int'(exp_done));
         chk("idle", int'(idle), int'(exp_done));
         if (exp_done) begin
            got_done = 1'b1;
            t_done   = cyc;
            chk("final_ptcnt", int'(pt_cnt), NP);
            chk("final_rready", int'(rr), 0);
         end else begin
            occ    = sent - beats / 3;
            exp_mv = (occ != 0);
            exp_rr = (occ < 2) && (sent < NP);
            chk("ptcnt", int'(pt_cnt), sent);
            chk("mvalid", int'(mv), int'(exp_mv));
            chk("rready", int'(rr), int'(exp_rr));
            if (exp_mv) begin
               chkd("mdata", mdata, mk_beat(mode, beats / 3, beats % 3));
               chk("mlast", int'(mlast), int'(beats == 3 * NP - 1));
            end
            exp_done = exp_mv && mr && (beats == 3 * NP - 1);
            if (rv && exp_rr) begin
               if (t_first < 0) t_first = cyc;
               sent++;
            end
            if (exp_mv && mr) beats++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      rv = 1'b0;
      mr = 1'b0;
      if (!got_done) begin
         errors++;
         checks++;
         $display("FAIL frame_timeout: got no done expected done within 6000 cycles");
      end
      chk("beats_total", beats, 3 * NP);
      if (chk_lat) chk("latency", t_done - t_first, 3 * NP + 1);
   endtask

   typedef struct {
      bit start;
      bit rv;
      int seed;
      bit mr;
      bit e_idle;
      bit e_rr;
      bit e_mv;
      bit e_done;
      int e_pt;
      int e_hp;
      int e_hk;
   } vec_t;

   vec_t tbl[14];

   initial begin
      int n;
      int guard;
      //          st rv sd mr  idl rr mv dn  pt hp hk
      tbl[0]  = '{0, 1, 0, 1,  1,  0, 0, 0,  0, 0, 0};   // gated before start
      tbl[1]  = '{0, 1, 0, 1,  1,  0, 0, 0,  0, 0, 0};
      tbl[2]  = '{1, 1, 0, 1,  1,  0, 0, 0,  0, 0, 0};   // start
      tbl[3]  = '{0, 1, 0, 0,  0,  1, 0, 0,  0, 0, 0};   // push p0
      tbl[4]  = '{0, 1, 1, 0,  0,  1, 1, 0,  1, 0, 0};   // push p1, stalled out
      tbl[5]  = '{0, 1, 2, 0,  0,  0, 1, 0,  2, 0, 0};   // full: ready drops
      tbl[6]  = '{1, 1, 2, 1,  0,  0, 1, 0,  2, 0, 0};   // start ignored
      tbl[7]  = '{0, 1, 2, 1,  0,  0, 1, 0,  2, 0, 1};
      tbl[8]  = '{0, 1, 2, 1,  0,  0, 1, 0,  2, 0, 2};   // pop of head: ready low
      tbl[9]  = '{0, 1, 2, 1,  0,  1, 1, 0,  2, 1, 0};   // ready back, push p2
      tbl[10] = '{0, 0, 0, 1,  0,  0, 1, 0,  3, 1, 1};
      tbl[11] = '{0, 0, 0, 0,  0,  0, 1, 0,  3, 1, 2};   // stall on beat 2
      tbl[12] = '{0, 0, 0, 1,  0,  0, 1, 0,  3, 1, 2};
      tbl[13] = '{0, 0, 0, 0,  0,  1, 1, 0,  3, 2, 0};

      rstN  = 1'b0;
      start = 1'b0;
      rv    = 1'b0;
      mr    = 1'b0;
      rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      rstN = 1'b1;

      for (int i = 0; i < 14; i++) begin
         start = tbl[i].start;
         rv    = tbl[i].rv;
         rdata = mk_point(1, tbl[i].seed);
         mr    = tbl[i].mr;
         #1;
         chk($sformatf("v%0d_idle", i), int'(idle), int'(tbl[i].e_idle));
         chk($sformatf("v%0d_rready", i), int'(rr), int'(tbl[i].e_rr));
         chk($sformatf("v%0d_mvalid", i), int'(mv), int'(tbl[i].e_mv));
         chk($sformatf("v%0d_done", i), int'(done), int'(tbl[i].e_done));
         chk($sformatf("v%0d_mlast", i), int'(mlast), 0);
         chk($sformatf("v%0d_ptcnt", i), int'(pt_cnt), tbl[i].e_pt);
         if (tbl[i].e_mv)
            chkd($sformatf("v%0d_mdata", i), mdata, mk_beat(1, tbl[i].e_hp, tbl[i].e_hk));
         @(posedge clk);
         #1;
      end
      start = 1'b0;

      // Finish the table's frame under random backpressure.
      run_frame(1'b0, 1, 1'b1, 3, 6, 1'b0);

      // Basic frame at full rate, latency measured.
      run_frame(1'b1, 0, 1'b0, 0, 0, 1'b1);

      // Reset mid-frame after 100 points.
      start = 1'b1;
      #1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n     = 0;
      guard = 0;
      while (n < 100 && guard < 1000) begin
         rv    = 1'b1;
         rdata = mk_point(0, n);
         mr    = 1'b1;
         #1;
         if (rr) n++;
         @(posedge clk);
         #1;
         guard++;
      end
      chk("pre_reset_points", n, 100);
      #2;
      rstN = 1'b0;
      #1;
      chk_reset_vals("midrst");
      rv = 1'b0;
      mr = 1'b0;
      @(posedge clk);
      #1;
      rstN = 1'b1;

      // Clean frame after reset.
      run_frame(1'b1, 1, 1'b0, 0, 0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/zprize_result_serializer.md
# zprize_result_serializer

Receiving end of the calc-group result stream. Accepts the 256 per-window points (128 sections × {sum, tmp}) that the group emits one 1536-bit point at a time over a valid/ready handshake. Buffers them and serializes each point into three 512-bit beats for the DDR/AXI writer, with a frame-level `m_last` on the final beat. It sits between the group's output port and the kernel's result write-back path.

## Interface
Parameters:
- `POINT_W`, 1536: width of one result point.
- `BEAT_W`, 512: output beat width; `POINT_W` must be an integer multiple of it. `BPP = POINT_W/BEAT_W`, which is 3.
- `NPOINTS`, 256: points per frame (`128*2`).

Ports:
- `clk` in 1: single clock.
- `rstN` in 1: reset, asynchronous, active-low.
- `start` in 1: arms one frame. Honoured only in IDLE.
- `idle` out 1: high in IDLE.
- `done` out 1: one-cycle pulse when the frame's last beat is accepted.
- `result_valid` in 1: point valid from the calc group.
- `result_ready` out 1: point accepted when `result_valid && result_ready`.
- `result_data` in `POINT_W`: point payload.
- `m_valid` out 1: beat valid.
- `m_ready` in 1: downstream ready.
- `m_data` out `BEAT_W`: beat payload.
- `m_last` out 1: high on the final beat of point `NPOINTS-1`.
- `pt_cnt` out 9: points accepted in the current frame.

## Operation
States:
- IDLE: `start` moves to RECV; `pt_cnt`, the beat index and the buffer pointers clear on entry to RECV.
- RECV: accept points, serialize beats. When the beat with `m_last` is accepted (`m_valid && m_ready && m_last`), pulse `done` and return to IDLE.

Input side:
- `result_ready = (state==RECV) && (buf_cnt < 2) && (pt_cnt < NPOINTS)`.
- `result_ready` is derived only from registered state. There is no combinational path from `m_ready` or `result_valid`.

Buffer:
- 2-entry point FIFO.
- Push on an input handshake; pop on acceptance of beat `BPP-1` of the head point.
- Push and pop in the same cycle are legal and leave `buf_cnt` unchanged.

Serializer:
- `beat_idx` counts 0..`BPP-1` within the head point.
- `m_data = head[beat_idx*BEAT_W +: BEAT_W]`, least-significant slice first.
- `beat_idx` advances on `m_valid && m_ready` and wraps to 0 after `BPP-1`.
- `m_valid = buf_cnt != 0`.
- `m_last = m_valid && beat_idx==BPP-1 && head is point NPOINTS-1`. This is tracked by a popped-point counter reaching `NPOINTS-1`.

`pt_cnt` increments on each input handshake and saturates at `NPOINTS`.

Boundary conditions:
- `result_valid` while IDLE or after `NPOINTS` points: not accepted; the point is held upstream.
- `start` outside IDLE: ignored.
- `m_ready` low: `m_data`, `m_last` and `beat_idx` are held stable while `m_valid`.
- Reset mid-frame: all state is dropped immediately; the buffered points are lost.

Reset values: `idle`=1, `done`=0, `result_ready`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `pt_cnt`=0.

## Timing
- A point accepted at cycle t has beat 0 valid on `m_valid` at t+1, because the buffer is registered.
- Beats 1 and 2 follow at t+2 and t+3 when `m_ready` is held high.
- Sustained throughput is 1 beat/cycle. The input accepts up to 1 point per `BPP` cycles without backpressuring the group; bursts of 2 points are absorbed.
- Frame latency from the first input handshake to `done`, with `m_ready` high and input at full rate: `NPOINTS*BPP + 1` cycles. That is 769.
- `done` asserts the cycle after the final beat handshake. `idle` rises in the same cycle.

## Structure
- Package `zprize_param` holds `ZPRIZE_POINT_W`, `ZPRIZE_BEAT_W` and `ZPRIZE_NPOINTS`, plus the state enum `zs_state_t` {ZS_IDLE, ZS_RECV}.
- Sub-module `zprize_pt_fifo2` is the 2-entry, `POINT_W`-wide register FIFO with `push`, `pop`, `cnt` and `head` ports.
- The serializer counters and the FSM live in the top.

## Test plan
- Basic frame: `start`, then 256 points back-to-back with `result_data = {3{i[511:0]}}`, `m_ready`=1. Expect 768 beats, each equal to `i`; `m_last` on beat 767 only; `done` one cycle later; `pt_cnt`=256.
- Slice order: point 0 = {C,B,A}, each 512 bits. Expect beats A, B, C in that order.
- Backpressure: toggle `m_ready` randomly at 50%. Expect no beat lost or duplicated and `m_data` stable while stalled. With `m_ready`=0, `result_ready` drops after 2 points are buffered.
- Gating: drive `result_valid`=1 before `start`. Expect `result_ready`=0 and no `m_valid`. After 256 points are accepted, a 257th point is not accepted.
- Simultaneous push/pop: buffer full, `m_ready`=1. At the pop of beat 2 of the head, `result_ready` is low that cycle and high the next. The FIFO order is preserved.
- Reset mid-frame: assert `rstN`=0 after 100 points. Expect all outputs at reset values asynchronously, then a clean full frame after the next `start`.
